// File: rtl/led_serial_ctrl.sv
// led_serial_ctrl: memory-mapped LED register with a serial driver for an external shift-register chain
module led_serial_ctrl #(
    parameter int NUM_LEDS  = 16,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        led_clk,
    output logic        led_do,
    output logic        led_pen
);
    localparam int NL = NUM_LEDS / 8;
    localparam int TW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(NUM_LEDS);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t              state;
    logic [NUM_LEDS-1:0] leds, leds_next, sreg;
    logic                dirty, accepted, unused_bits;
    logic [TW-1:0]       tick;
    logic [BW-1:0]       bitcnt;

    assign accepted    = |we[NL-1:0];
    assign unused_bits = ^{we, wdata};
    assign rdata       = {busy, dirty, {(30 - NUM_LEDS){1'b0}}, leds};

    // Per-lane read-modify-write; lanes beyond the LED count are never touched
    always_comb begin
        leds_next = leds;
        for (int b = 0; b < NL; b++)
            if (we[b])
                leds_next[8*b+:8] = addr == 2'd0 ? wdata[8*b+:8] :
                                    addr == 2'd1 ? leds[8*b+:8] | wdata[8*b+:8] :
                                    addr == 2'd2 ? leds[8*b+:8] & ~wdata[8*b+:8] :
                                                   leds[8*b+:8] ^ wdata[8*b+:8];
    end

    // LED register and refresh-request flag; a write during LOAD wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            leds  <= '0;
            dirty <= 1'b1;
        end else begin
            leds  <= leds_next;
            dirty <= accepted | (dirty & (state != LOAD));
        end
    end

    // Frame sequencer with registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            tick    <= '0;
            bitcnt  <= '0;
            led_clk <= 1'b0;
            led_do  <= 1'b0;
            led_pen <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dirty) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: begin
                    state   <= SHIFT;
                    sreg    <= leds;
                    bitcnt  <= '0;
                    tick    <= '0;
                    led_clk <= 1'b0;
                    led_do  <= MSB_FIRST ? leds[NUM_LEDS-1] : leds[0];
                end
                SHIFT: begin
                    tick <= tick == TICK_LAST ? '0 : tick + 1'b1;
                    if (tick == TICK_HALF)
                        led_clk <= 1'b1;
                    if (tick == TICK_LAST) begin
                        led_clk <= 1'b0;
                        sreg    <= MSB_FIRST ? {sreg[NUM_LEDS-2:0], 1'b0} : {1'b0, sreg[NUM_LEDS-1:1]};
                        if (bitcnt == BIT_LAST) begin
                            state   <= LATCH;
                            led_do  <= 1'b0;
                            led_pen <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            led_do <= MSB_FIRST ? sreg[NUM_LEDS-2] : sreg[1];
                        end
                    end
                end
                LATCH: begin
                    tick <= tick + 1'b1;
                    if (tick == TICK_LAST) begin
                        state   <= IDLE;
                        tick    <= '0;
                        led_pen <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_serial_ctrl.sv
// tb_led_serial_ctrl: directed self-checking bench for led_serial_ctrl (16 LEDs, CLK_DIV=2, MSB first)
module tb_led_serial_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  we = '0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, led_clk, led_do, led_pen;

    int checks = 0;
    int errors = 0;

    int          nframes = 0;
    int          nbits = 0, last_nbits = 0;
    int          pen_w = 0, last_pen_w = 0;
    int          busy_run = 0, last_busy = 0;
    logic [31:0] cap = '0;
    logic [15:0] last_frame = '0;
    logic        pclk = 1'b0;

    led_serial_ctrl #(.NUM_LEDS(16), .CLK_DIV(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .led_clk(led_clk), .led_do(led_do), .led_pen(led_pen)
    );

    always #5 clk = ~clk;

    // Chain model: collect bits on led_clk rising edges, close a frame when led_pen falls
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0; cap = '0; pen_w = 0; busy_run = 0;
        end else begin
            if (led_clk && !pclk) begin
                cap = {cap[30:0], led_do};
                nbits++;
            end
            if (led_pen) pen_w++;
            else if (pen_w != 0) begin
                last_pen_w = pen_w; pen_w = 0;
                last_frame = cap[15:0]; last_nbits = nbits;
                cap = '0; nbits = 0; nframes++;
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy = busy_run; busy_run = 0;
            end
        end
        pclk = led_clk;
    end

    task automatic wait_idle(output bit to);
        int n = 0;
        @(negedge clk);
        while ((busy || rdata[30]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 500);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        addr = a; we = w; wdata = d;
        @(negedge clk);
        we = '0;
    endtask

    task automatic test_reset;
        bit to;
        int f0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h4000_0000 || busy !== 1'b0 || led_clk !== 1'b0 || led_do !== 1'b0 || led_pen !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h busy=%b clk=%b do=%b pen=%b, want 40000000 0 0 0 0", rdata, busy, led_clk, led_do, led_pen);
        end
        f0 = nframes;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_rise: busy=%b want 1", busy); end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL reset_timeout: frame never ended"); end
        checks++;
        if (last_busy != 69) begin errors++; $display("FAIL reset_busy_len: got %0d want 69", last_busy); end
        checks++;
        if (nframes != f0 + 1 || last_nbits != 16 || last_frame !== 16'h0000) begin
            errors++;
            $display("FAIL reset_frame: frames=%0d bits=%0d data=%h want %0d 16 0000", nframes - f0, last_nbits, last_frame, 1);
        end
        checks++;
        if (last_pen_w != 4 || busy !== 1'b0) begin errors++; $display("FAIL reset_pen: width=%0d busy=%b want 4 0", last_pen_w, busy); end
    endtask

    task automatic test_write;
        bit to;
        int f0 = nframes;
        do_write(2'd0, 4'b0011, 32'h0000_A55A);
        checks++;
        if (rdata !== 32'h4000_A55A) begin errors++; $display("FAIL write_rdata: got %h want 4000a55a", rdata); end
        wait_idle(to);
        checks++;
        if (to) begin errors++; $display("FAIL write_timeout: frame never ended"); end
        checks++;
        if (nframes != f0 + 1 || last_nbits != 16 || last_frame !== 16'hA55A) begin
            errors++;
            $display("FAIL write_frame: frames=%0d bits=%0d data=%h want 1 16 a55a", nframes - f0, last_nbits, last_frame);
        end
        checks++;
        if (last_pen_w != 4) begin errors++; $display("FAIL write_pen: width=%0d want 4", last_pen_w); end
    endtask

    task automatic test_lane_ops;
        bit to;
        do_write(2'd1, 4'b0010, 32'h0000_0F00);
        checks++;
        if (rdata[15:0] !== 16'hAF5A) begin errors++; $display("FAIL op_set: got %h want af5a", rdata[15:0]); end
        do_write(2'd2, 4'b0001, 32'h0000_00FF);
        checks++;
        if (rdata[15:0] !== 16'hAF00) begin errors++; $display("FAIL op_clear: got %h want af00", rdata[15:0]); end
        do_write(2'd3, 4'b0011, 32'h0000_FFFF);
        checks++;
        if (rdata[15:0] !== 16'h50FF) begin errors++; $display("FAIL op_toggle: got %h want 50ff", rdata[15:0]); end
        wait_idle(to);
        checks++;
        if (to || last_frame !== 16'h50FF || last_nbits != 16) begin
            errors++;
            $display("FAIL op_frame: timeout=%b data=%h bits=%0d want 0 50ff 16", to, last_frame, last_nbits);
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        int n = 0;
        int f0 = nframes;
        do_write(2'd0, 4'b0011, 32'h0000_A55A);
        repeat (20) @(negedge clk);
        do_write(2'd0, 4'b0011, 32'h0000_1111);
        repeat (2) @(negedge clk);
        do_write(2'd0, 4'b0011, 32'h0000_2222);
        repeat (2) @(negedge clk);
        do_write(2'd0, 4'b0011, 32'h0000_3333);
        while (nframes == f0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (nframes != f0 + 1 || last_frame !== 16'hA55A) begin
            errors++;
            $display("FAIL b2b_first: frames=%0d data=%h want 1 a55a", nframes - f0, last_frame);
        end
        wait_idle(to);
        checks++;
        if (to || nframes != f0 + 2 || last_frame !== 16'h3333 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: timeout=%b frames=%0d data=%h busy=%b want 0 2 3333 0", to, nframes - f0, last_frame, busy);
        end
    endtask

    task automatic test_invalid_lanes;
        int f0 = nframes;
        int clk_hi = 0;
        do_write(2'd0, 4'b1100, 32'hFFFF_FFFF);
        checks++;
        if (rdata !== 32'h0000_3333) begin errors++; $display("FAIL inv_rdata: got %h want 00003333", rdata); end
        repeat (20) begin
            @(negedge clk);
            if (led_clk || busy) clk_hi++;
        end
        checks++;
        if (clk_hi != 0 || nframes != f0 || rdata !== 32'h0000_3333) begin
            errors++;
            $display("FAIL inv_noframe: active=%0d frames=%0d rdata=%h want 0 0 00003333", clk_hi, nframes - f0, rdata);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int n = 0;
        int f0;
        do_write(2'd0, 4'b0011, 32'h0000_FFFF);
        while (nbits < 7 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (nbits != 7 || led_do !== 1'b1) begin errors++; $display("FAIL mid_reach: bits=%0d do=%b want 7 1", nbits, led_do); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (led_clk !== 1'b0 || led_do !== 1'b0 || led_pen !== 1'b0 || rdata !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mid_abort: clk=%b do=%b pen=%b rdata=%h want 0 0 0 40000000", led_clk, led_do, led_pen, rdata);
        end
        f0 = nframes;
        rst = 1'b0;
        wait_idle(to);
        checks++;
        if (to || nframes != f0 + 1 || last_frame !== 16'h0000 || last_nbits != 16) begin
            errors++;
            $display("FAIL mid_refresh: timeout=%b frames=%0d data=%h bits=%0d want 0 1 0000 16", to, nframes - f0, last_frame, last_nbits);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_lane_ops;
        test_back_to_back;
        test_invalid_lanes;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
